// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with valid/ready handshake,
// two-entry skid buffer (main + skid) and synchronous flush to a bubble.
// in_ready is decoded from the state register only, so there is no
// combinational path from out_ready to in_ready.
// Optional macro PIPE_SKID_STATS_EN adds a saturating stall-cycle counter
// (stall_cnt) and its COUNT_BITS parameter.
module pipe_skid_reg #(
    parameter int                   DATA_BITS    = 32,
    parameter logic [DATA_BITS-1:0] BUBBLE_VALUE = '0
`ifdef PIPE_SKID_STATS_EN
    ,
    parameter int                   COUNT_BITS   = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_BITS-1:0]  in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_BITS-1:0]  out_data
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [COUNT_BITS-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] main_q;
    logic [DATA_BITS-1:0] skid_q;
    logic                 accept;
    logic                 emit;

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    // Occupancy FSM and storage; flush beats every handshake, and any
    // unused encoding falls back to EMPTY with both registers bubbled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            main_q <= BUBBLE_VALUE;
            skid_q <= BUBBLE_VALUE;
        end else if (flush) begin
            state  <= EMPTY;
            main_q <= BUBBLE_VALUE;
            skid_q <= BUBBLE_VALUE;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state  <= BUSY;
                        main_q <= in_data;
                    end
                end
                BUSY: begin
                    if (accept && emit) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        state  <= FULL;
                        skid_q <= in_data;
                    end else if (emit) begin
                        state  <= EMPTY;
                        main_q <= BUBBLE_VALUE;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (emit) begin
                        state  <= BUSY;
                        main_q <= skid_q;
                        skid_q <= BUBBLE_VALUE;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    main_q <= BUBBLE_VALUE;
                    skid_q <= BUBBLE_VALUE;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STATS_EN
    // Count cycles where a valid beat is held back; saturate, reset-only clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {COUNT_BITS{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
